// File: rtl/turn_signal_decoder_pkg.sv
// Shared types and constants for the turn signal lamp-side decoder.
package turn_signal_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_L_RUN = 3'd1,
    S_R_RUN = 3'd2,
    S_FAULT = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_PATTERN = 2'b01;
  localparam logic [1:0] FC_DWELL   = 2'b10;
  localparam logic [1:0] FC_BOTH    = 2'b11;

  localparam logic [2:0] L_P0 = 3'b000;
  localparam logic [2:0] L_P1 = 3'b001;
  localparam logic [2:0] L_P2 = 3'b011;
  localparam logic [2:0] L_P3 = 3'b111;
  localparam logic [2:0] R_P0 = 3'b000;
  localparam logic [2:0] R_P1 = 3'b100;
  localparam logic [2:0] R_P2 = 3'b110;
  localparam logic [2:0] R_P3 = 3'b111;

endpackage

// File: rtl/turn_signal_decoder_if.sv
// Lamp buses and status outputs between controller side (master) and decoder (slave).
interface turn_signal_decoder_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       l_signal;
  logic [2:0]       r_signal;
  logic             error_in;
  logic             left_active;
  logic             right_active;
  logic [1:0]       phase;
  logic             fault;
  logic [1:0]       fault_code;
  logic             error_seen;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output l_signal, r_signal, error_in,
    input  left_active, right_active, phase, fault, fault_code, error_seen, cycle_count
  );

  modport slave (
    input  l_signal, r_signal, error_in,
    output left_active, right_active, phase, fault, fault_code, error_seen, cycle_count
  );
endinterface

// File: rtl/tsd_pattern_classify.sv
// Maps a 3-bit lamp bus to its sweep phase (0..3) for the selected side; flags non-sweep patterns.
module tsd_pattern_classify
  import turn_signal_pkg::*;
(
  input  logic [2:0] bus_i,
  input  side_e      side_i,
  output logic [1:0] ph_o,
  output logic       illegal_o
);

  always_comb begin
    ph_o      = 2'd0;
    illegal_o = 1'b0;
    if (side_i == SIDE_L) begin
      case (bus_i)
        L_P0:    ph_o = 2'd0;
        L_P1:    ph_o = 2'd1;
        L_P2:    ph_o = 2'd2;
        L_P3:    ph_o = 2'd3;
        default: illegal_o = 1'b1;
      endcase
    end else begin
      case (bus_i)
        R_P0:    ph_o = 2'd0;
        R_P1:    ph_o = 2'd1;
        R_P2:    ph_o = 2'd2;
        R_P3:    ph_o = 2'd3;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/turn_signal_decoder.sv
// Lamp-side monitor: tracks sweep side/phase, checks sequence and dwell, counts sweeps.
// Optional macro TSD_CYCLE_COUNT_EN enables the completed-sweep counter; otherwise it reads 0.
module turn_signal_decoder
  import turn_signal_pkg::*;
#(
  parameter int DWELL = 3,
  parameter int CNT_W = 8
) (
  input  logic clock,
  input  logic reset,
  turn_signal_decoder_if.slave bus
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL);

  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [1:0]      idle_q, idle_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;
  logic            cnt_inc, cnt_clr;

  logic [1:0] l_ph, r_ph, a_ph;
  logic       l_ill, r_ill, a_ill;
  logic       l_nz, r_nz, b_nz, act_left;
  logic       go_fault;
  logic [1:0] fcause;

  tsd_pattern_classify u_cls_l (.bus_i(bus.l_signal), .side_i(SIDE_L), .ph_o(l_ph), .illegal_o(l_ill));
  tsd_pattern_classify u_cls_r (.bus_i(bus.r_signal), .side_i(SIDE_R), .ph_o(r_ph), .illegal_o(r_ill));

  assign l_nz     = |bus.l_signal;
  assign r_nz     = |bus.r_signal;
  assign act_left = (state_q == S_L_RUN);
  assign a_ph     = act_left ? l_ph  : r_ph;
  assign a_ill    = act_left ? l_ill : r_ill;
  assign b_nz     = act_left ? r_nz  : l_nz;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    idle_d   = idle_q;
    fault_d  = fault_q;
    code_d   = code_q;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    go_fault = 1'b0;
    fcause   = FC_NONE;

    if (bus.error_in) begin
      state_d = S_ERR;
      phase_d = 2'd0;
      dwell_d = '0;
      idle_d  = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!l_nz && !r_nz) begin
            idle_d = (idle_q == 2'd2) ? 2'd2 : idle_q + 2'd1;
          end else if (l_ph == 2'd1 && !r_nz) begin
            state_d = S_L_RUN;
            phase_d = 2'd1;
            dwell_d = DW_W'(1);
            idle_d  = 2'd0;
            cnt_clr = (idle_q >= 2'd2);
          end else if (r_ph == 2'd1 && !l_nz) begin
            state_d = S_R_RUN;
            phase_d = 2'd1;
            dwell_d = DW_W'(1);
            idle_d  = 2'd0;
            cnt_clr = (idle_q >= 2'd2);
          end else begin
            go_fault = 1'b1;
            fcause   = (l_nz && r_nz) ? FC_BOTH : FC_PATTERN;
          end
        end

        S_L_RUN, S_R_RUN: begin
          if (b_nz) begin
            go_fault = 1'b1;
            fcause   = FC_BOTH;
          end else if (a_ill) begin
            go_fault = 1'b1;
            fcause   = FC_PATTERN;
          end else if (a_ph == phase_q) begin
            if (dwell_q < DW_MAX) dwell_d = dwell_q + 1'b1;
            else begin
              go_fault = 1'b1;
              fcause   = FC_DWELL;
            end
          end else if (a_ph == 2'd0) begin
            // Dark after a full dwell is a legal release; only a full p3 counts as a sweep.
            if (dwell_q == DW_MAX) begin
              state_d = S_IDLE;
              phase_d = 2'd0;
              dwell_d = '0;
              idle_d  = 2'd1;
              cnt_inc = (phase_q == 2'd3);
            end else begin
              go_fault = 1'b1;
              fcause   = FC_DWELL;
            end
          end else if (a_ph == phase_q + 2'd1) begin
            if (dwell_q == DW_MAX) begin
              phase_d = a_ph;
              dwell_d = DW_W'(1);
            end else begin
              go_fault = 1'b1;
              fcause   = FC_DWELL;
            end
          end else begin
            go_fault = 1'b1;
            fcause   = FC_PATTERN;
          end
        end

        S_FAULT: begin
          // idle_q doubles as the dark-run counter while parked in FAULT.
          if (!l_nz && !r_nz) begin
            if (idle_q >= 2'd1) begin
              state_d = S_IDLE;
              idle_d  = 2'd2;
              fault_d = 1'b0;
              code_d  = FC_NONE;
              cnt_clr = 1'b1;
            end else begin
              idle_d = 2'd1;
            end
          end else begin
            idle_d = 2'd0;
          end
        end

        S_ERR: begin
          if (!l_nz && !r_nz) begin
            state_d = S_IDLE;
            idle_d  = 2'd0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (go_fault) begin
      state_d = S_FAULT;
      phase_d = 2'd0;
      dwell_d = '0;
      idle_d  = 2'd0;
      fault_d = 1'b1;
      if (!fault_q) code_d = fcause;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      dwell_q <= '0;
      idle_q  <= 2'd0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      idle_q  <= idle_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

`ifdef TSD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (cnt_inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.cycle_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt      = cnt_inc | cnt_clr;
  assign bus.cycle_count = '0;
`endif

  assign bus.left_active  = (state_q == S_L_RUN);
  assign bus.right_active = (state_q == S_R_RUN);
  assign bus.phase        = phase_q;
  assign bus.fault        = fault_q;
  assign bus.fault_code   = code_q;
  assign bus.error_seen   = (state_q == S_ERR);

endmodule

// File: tb/tb_turn_signal_decoder.sv
// Directed-vector bench for turn_signal_decoder; expectations follow TSD_CYCLE_COUNT_EN.
module tb_turn_signal_decoder;
  localparam int CNT_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  turn_signal_decoder_if #(.CNT_W(CNT_W)) bus ();

  turn_signal_decoder #(.DWELL(3), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic int ec(input int n);
`ifdef TSD_CYCLE_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply one input vector, let it be sampled, then settle past the edge.
  task automatic step(input logic [2:0] l, input logic [2:0] r, input logic e);
    bus.l_signal = l;
    bus.r_signal = r;
    bus.error_in = e;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_run(input string tag, input bit left, input int ph);
    chk({tag, ".la"}, int'(bus.left_active), left ? 1 : 0);
    chk({tag, ".ra"}, int'(bus.right_active), left ? 0 : 1);
    chk({tag, ".ph"}, int'(bus.phase), ph);
  endtask

  task automatic sweep(input string tag, input bit left);
    logic [2:0] pat [3];
    if (left) begin pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111; end
    else      begin pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b111; end
    for (int p = 0; p < 3; p++)
      for (int d = 0; d < 3; d++) begin
        if (left) step(pat[p], 3'b000, 1'b0);
        else      step(3'b000, pat[p], 1'b0);
        chk_run(tag, left, p + 1);
      end
    step(3'b000, 3'b000, 1'b0);
    chk({tag, ".rel_la"}, int'(bus.left_active), 0);
    chk({tag, ".rel_ra"}, int'(bus.right_active), 0);
    chk({tag, ".rel_ph"}, int'(bus.phase), 0);
  endtask

  initial begin
    bus.l_signal = 3'b000;
    bus.r_signal = 3'b000;
    bus.error_in = 1'b0;
    reset = 1'b1;
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk("rst.la", int'(bus.left_active), 0);
    chk("rst.ra", int'(bus.right_active), 0);
    chk("rst.ph", int'(bus.phase), 0);
    chk("rst.fault", int'(bus.fault), 0);
    chk("rst.code", int'(bus.fault_code), 0);
    chk("rst.err", int'(bus.error_seen), 0);
    chk("rst.cnt", int'(bus.cycle_count), 0);
    reset = 1'b0;

    // Full left sweep
    sweep("lsw", 1'b1);
    chk("lsw.cnt", int'(bus.cycle_count), ec(1));
    chk("lsw.fault", int'(bus.fault), 0);
    step(3'b000, 3'b000, 1'b0);

    // Early step on the right side
    step(3'b000, 3'b100, 1'b0); chk_run("early1", 1'b0, 1);
    chk("early.cntclr", int'(bus.cycle_count), 0);
    step(3'b000, 3'b100, 1'b0); chk_run("early2", 1'b0, 1);
    step(3'b000, 3'b110, 1'b0);
    chk("early.fault", int'(bus.fault), 1);
    chk("early.code", int'(bus.fault_code), 2);
    chk("early.ra", int'(bus.right_active), 0);
    step(3'b000, 3'b000, 1'b0);
    chk("early.hold", int'(bus.fault), 1);
    step(3'b000, 3'b000, 1'b0);
    chk("early.rec", int'(bus.fault), 0);
    chk("early.reccode", int'(bus.fault_code), 0);
    chk("early.reccnt", int'(bus.cycle_count), 0);

    // Both sides lit mid left sweep
    for (int d = 0; d < 3; d++) step(3'b001, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0); chk_run("both.pre", 1'b1, 2);
    step(3'b011, 3'b100, 1'b0);
    chk("both.fault", int'(bus.fault), 1);
    chk("both.code", int'(bus.fault_code), 3);
    chk("both.la", int'(bus.left_active), 0);
    // A later violation while faulted must not overwrite the first cause
    step(3'b101, 3'b000, 1'b0);
    chk("both.sticky", int'(bus.fault_code), 3);
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    chk("both.rec", int'(bus.fault), 0);

    // Illegal pattern from IDLE
    step(3'b101, 3'b000, 1'b0);
    chk("ill.fault", int'(bus.fault), 1);
    chk("ill.code", int'(bus.fault_code), 1);
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);

    // Holding a phase one clock too long
    for (int d = 0; d < 3; d++) step(3'b001, 3'b000, 1'b0);
    chk_run("dwell.pre", 1'b1, 1);
    step(3'b001, 3'b000, 1'b0);
    chk("dwell.code", int'(bus.fault_code), 2);
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);

    // Error beats a concurrent violation
    step(3'b111, 3'b111, 1'b1);
    chk("err.seen", int'(bus.error_seen), 1);
    chk("err.fault", int'(bus.fault), 0);
    chk("err.la", int'(bus.left_active), 0);
    step(3'b000, 3'b000, 1'b0);
    chk("err.exit", int'(bus.error_seen), 0);
    chk("err.fault2", int'(bus.fault), 0);

    // Back-to-back right sweeps
    sweep("rsw1", 1'b0);
    chk("rsw1.cnt", int'(bus.cycle_count), ec(1));
    sweep("rsw2", 1'b0);
    chk("rsw2.cnt", int'(bus.cycle_count), ec(2));

    // Reset at dwell 2 of phase 2
    for (int d = 0; d < 3; d++) step(3'b000, 3'b100, 1'b0);
    step(3'b000, 3'b110, 1'b0);
    step(3'b000, 3'b110, 1'b0); chk_run("mid", 1'b0, 2);
    reset = 1'b1;
    step(3'b000, 3'b110, 1'b0);
    chk("mrst.ra", int'(bus.right_active), 0);
    chk("mrst.ph", int'(bus.phase), 0);
    chk("mrst.fault", int'(bus.fault), 0);
    chk("mrst.cnt", int'(bus.cycle_count), 0);
    reset = 1'b0;
    step(3'b001, 3'b000, 1'b0);
    chk_run("restart", 1'b1, 1);
    chk("restart.cnt", int'(bus.cycle_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
